// File: rtl/conv_requant_if.sv
// conv_requant_if: stream bundle between the convolution core, the requant
// stage and the output buffer. The upstream beat (partials, bias, shift)
// and the downstream 32-bit word stream share this one interface.
// master = the side that feeds beats and consumes words; slave = conv_requant.
interface conv_requant_if #(
  parameter int NF     = 16,
  parameter int PSUM_W = 20
);
  logic                   in_valid;
  logic                   in_ready;
  logic [NF*6*PSUM_W-1:0] in_psum;
  logic [NF*16-1:0]       bias;
  logic [4:0]             shift;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_data;
  logic                   out_last;

  modport master (
    output in_valid, in_psum, bias, shift, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_psum, bias, shift, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv_requant.sv
// conv_requant: output stage of the 16-filter 3x3 convolution core.
// Per beat: sums three row partials per column, adds the filter bias,
// rounds half-up, arithmetic-shifts, saturates to int8 and streams the
// 2*NF result bytes as NF/2 32-bit words.
// Optional build macro CONV_RELU_EN clamps negative results to zero.
module conv_requant #(
  parameter int NF     = 16,
  parameter int PSUM_W = 20
) (
  input  logic          clk,
  input  logic          reset,
  conv_requant_if.slave bus
);
  localparam int SW  = PSUM_W + 2;   // three-row sum
  localparam int TW  = PSUM_W + 3;   // sum plus bias
  localparam int RW  = TW + 33;      // headroom for a 2^30 rounding term
  localparam int NW  = NF / 2;
  localparam int WIW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [WIW-1:0]       W_LAST = WIW'(NW - 1);
  localparam logic signed [RW-1:0] MAXV   = 127;
  localparam logic signed [RW-1:0] MINV   = -128;

  typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [WIW-1:0]         w;
  logic [NF*6*PSUM_W-1:0] psum_p0;
  logic [NF*16-1:0]       bias_p0;
  logic [4:0]             shift_p0;
  logic [NF*16-1:0]       res_nxt;
  logic [NF*16-1:0]       res_p1;
  logic                   accept;
  logic                   last_word;

  // Round half-up toward +inf, then arithmetic shift. Done wide so that the
  // rounding term 1<<(shift-1) never wraps for large shifts.
  function automatic logic signed [RW-1:0] round_shift(
    input logic signed [TW-1:0] t,
    input logic [4:0]           sh
  );
    logic signed [RW-1:0] r;
    r = {{(RW-TW){t[TW-1]}}, t};
    if (sh != 5'd0) r = r + ({{(RW-1){1'b0}}, 1'b1} << (sh - 5'd1));
    return r >>> sh;
  endfunction

  // Clamp to the int8 range.
  function automatic logic signed [7:0] sat8(input logic signed [RW-1:0] v);
    logic signed [7:0] q;
    if (v > MAXV)      q = 8'sh7f;
    else if (v < MINV) q = 8'sh80;
    else               q = v[7:0];
    return q;
  endfunction

  // One output byte: row sum, bias, round/shift, saturate (and ReLU).
  function automatic logic signed [7:0] requant(
    input logic signed [PSUM_W-1:0] p1,
    input logic signed [PSUM_W-1:0] p2,
    input logic signed [PSUM_W-1:0] p3,
    input logic signed [15:0]       b,
    input logic [4:0]               sh
  );
    logic signed [SW-1:0] s;
    logic signed [TW-1:0] t;
    logic signed [7:0]    q;
    s = {{2{p1[PSUM_W-1]}}, p1} + {{2{p2[PSUM_W-1]}}, p2} + {{2{p3[PSUM_W-1]}}, p3};
    t = {{(TW-SW){s[SW-1]}}, s} + {{(TW-16){b[15]}}, b};
    q = sat8(round_shift(t, sh));
`ifdef CONV_RELU_EN
    if (q[7]) q = 8'sd0;
`else
    q = q;
`endif
    return q;
  endfunction

  assign accept    = (state == IDLE) && bus.in_valid;
  assign last_word = bus.out_ready && (w == W_LAST);

  // Stage p0: capture the beat together with the bias and shift it must use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psum_p0  <= '0;
      bias_p0  <= '0;
      shift_p0 <= '0;
    end else if (accept) begin
      psum_p0  <= bus.in_psum;
      bias_p0  <= bus.bias;
      shift_p0 <= bus.shift;
    end
  end

  // Compute every result byte from the captured beat; byte index f*2+c
  // already matches the output word lane order.
  always_comb begin
    res_nxt = '0;
    for (int f = 0; f < NF; f++) begin
      for (int c = 0; c < 2; c++) begin
        res_nxt[(f*2+c)*8 +: 8] = requant(psum_p0[(f*6+c*3+0)*PSUM_W +: PSUM_W],
                                          psum_p0[(f*6+c*3+1)*PSUM_W +: PSUM_W],
                                          psum_p0[(f*6+c*3+2)*PSUM_W +: PSUM_W],
                                          bias_p0[f*16 +: 16],
                                          shift_p0);
      end
    end
  end

  // Stage p1: result register, loaded during the single CALC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               res_p1 <= '0;
    else if (state == CALC)  res_p1 <= res_nxt;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Word index: cleared entering SEND, advanced on each accepted word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w <= '0;
    end else if (state == CALC) begin
      w <= '0;
    end else if (state == SEND && bus.out_ready) begin
      w <= (w == W_LAST) ? '0 : w + 1'b1;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    state_nxt = SEND;
      SEND:    if (last_word) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are pure decodes of registered state; out_ready never reaches in_ready.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == SEND);
    bus.out_last  = (state == SEND) && (w == W_LAST);
    bus.out_data  = (state == SEND) ? res_p1[w*32 +: 32] : 32'd0;
  end
endmodule
